key_event_arbiter: RTL and testbench

//   Collects the single-cycle press_down/press_up pulses from NUM_KEYS per-key

---
 rtl/key_event_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_key_event_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_arbiter.sv
// Serialises per-key press/release/long-press pulses into one valid/ready event stream, served round-robin.
// Optional long-press detection is built only when KEY_EVT_LONG_PRESS_EN is defined.
module key_event_arbiter #(
  parameter int NUM_KEYS    = 4,
  parameter int IDX_W       = $clog2(NUM_KEYS),
  parameter int LONG_CYCLES = 50
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] press_down,
  input  logic [NUM_KEYS-1:0] press_up,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [IDX_W-1:0]    evt_key,
  output logic [1:0]          evt_type,
  output logic [NUM_KEYS-1:0] ovf,
  input  logic                ovf_clr,
  output logic [1:0]          dbg_state_o,
  output logic [IDX_W-1:0]    dbg_ptr_o
);

  // Handshake: an event transfers on a rising clk edge where evt_valid && evt_ready;
  // evt_key/evt_type are held stable while evt_valid && !evt_ready.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] T_DOWN = 2'b00;
  localparam logic [1:0] T_UP   = 2'b01;
  localparam logic [1:0] T_LONG = 2'b10;
  localparam logic [NUM_KEYS-1:0] ONE = {{(NUM_KEYS-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [NUM_KEYS-1:0] pend_dn_q, pend_dn_d;
  logic [NUM_KEYS-1:0] pend_up_q, pend_up_d;
  logic [NUM_KEYS-1:0] pend_lg;
  logic [NUM_KEYS-1:0] lg_ovf;
  logic [NUM_KEYS-1:0] ovf_q, ovf_d;
  logic [NUM_KEYS-1:0] grant_oh, clr_dn, clr_up;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    sel_key;
  logic [1:0]          sel_type;
  logic                sel_found;
  logic                any_pend;
  logic                grant;
  logic                xfer;
  logic                evt_valid_q, evt_valid_d;
  logic [IDX_W-1:0]    evt_key_q, evt_key_d;
  logic [1:0]          evt_type_q, evt_type_d;

  assign any_pend = |{pend_dn_q, pend_up_q, pend_lg};
  assign xfer     = evt_valid_q & evt_ready;
  assign grant    = (state_q == S_GRANT) && sel_found;

  // Round-robin search from ptr; within a key, down beats long beats up.
  always_comb begin
    int idx;
    sel_found = 1'b0;
    sel_key   = '0;
    sel_type  = T_DOWN;
    idx       = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_KEYS) idx = idx - NUM_KEYS;
      if (!sel_found && (pend_dn_q[idx] || pend_up_q[idx] || pend_lg[idx])) begin
        sel_found = 1'b1;
        sel_key   = IDX_W'(idx);
        if (pend_dn_q[idx])    sel_type = T_DOWN;
        else if (pend_lg[idx]) sel_type = T_LONG;
        else                   sel_type = T_UP;
      end
    end
  end

  assign grant_oh = grant ? (ONE << sel_key) : '0;
  assign clr_dn   = (sel_type == T_DOWN) ? grant_oh : '0;
  assign clr_up   = (sel_type == T_UP)   ? grant_oh : '0;

  // A pulse landing on a flag being granted this cycle re-arms it instead of overflowing.
  assign pend_dn_d = (pend_dn_q & ~clr_dn) | press_down;
  assign pend_up_d = (pend_up_q & ~clr_up) | press_up;
  assign ovf_d     = (press_down & pend_dn_q & ~clr_dn)
                   | (press_up & pend_up_q & ~clr_up)
                   | lg_ovf
                   | (ovf_clr ? '0 : ovf_q);

`ifdef KEY_EVT_LONG_PRESS_EN
  localparam int CNT_W = $clog2(LONG_CYCLES + 1);

  logic [NUM_KEYS-1:0] armed_q, armed_d;
  logic [NUM_KEYS-1:0] pend_lg_q, pend_lg_d;
  logic [NUM_KEYS-1:0] lg_hit;
  logic [NUM_KEYS-1:0] clr_lg;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];

  // The last counted cycle raises pend_lg directly, so the long flag lands LONG_CYCLES after the down flag.
  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      lg_hit[k]  = armed_q[k] && (cnt_q[k] == CNT_W'(LONG_CYCLES - 1))
                   && !press_down[k] && !press_up[k];
      armed_d[k] = armed_q[k];
      cnt_d[k]   = cnt_q[k];
      if (press_up[k]) begin
        armed_d[k] = 1'b0;
        cnt_d[k]   = '0;
      end else if (press_down[k]) begin
        armed_d[k] = 1'b1;
        cnt_d[k]   = '0;
      end else if (lg_hit[k]) begin
        armed_d[k] = 1'b0;
        cnt_d[k]   = '0;
      end else if (armed_q[k]) begin
        cnt_d[k]   = cnt_q[k] + 1'b1;
      end
    end
  end

  assign clr_lg    = (sel_type == T_LONG) ? grant_oh : '0;
  assign pend_lg_d = (pend_lg_q & ~clr_lg) | lg_hit;
  assign lg_ovf    = lg_hit & pend_lg_q & ~clr_lg;
  assign pend_lg   = pend_lg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q   <= '0;
      pend_lg_q <= '0;
      for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= '0;
    end else begin
      armed_q   <= armed_d;
      pend_lg_q <= pend_lg_d;
      for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= cnt_d[k];
    end
  end
`else
  assign pend_lg = '0;
  assign lg_ovf  = '0;

  // The hold threshold only matters when long-press detection is built.
  if (LONG_CYCLES < 1) begin : g_long_cycles_unused
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_pend) state_d = S_GRANT;
      S_GRANT: state_d = sel_found ? S_HOLD : S_IDLE;
      S_HOLD:  if (xfer) state_d = any_pend ? S_GRANT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_key_d   = evt_key_q;
    evt_type_d  = evt_type_q;
    ptr_d       = ptr_q;
    case (state_q)
      S_GRANT: begin
        if (sel_found) begin
          evt_valid_d = 1'b1;
          evt_key_d   = sel_key;
          evt_type_d  = sel_type;
          ptr_d       = (sel_key == IDX_W'(NUM_KEYS - 1)) ? '0 : sel_key + 1'b1;
        end
      end
      S_HOLD:  if (xfer) evt_valid_d = 1'b0;
      default: evt_valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_dn_q   <= '0;
      pend_up_q   <= '0;
      ovf_q       <= '0;
      ptr_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_key_q   <= '0;
      evt_type_q  <= T_DOWN;
    end else begin
      pend_dn_q   <= pend_dn_d;
      pend_up_q   <= pend_up_d;
      ovf_q       <= ovf_d;
      ptr_q       <= ptr_d;
      evt_valid_q <= evt_valid_d;
      evt_key_q   <= evt_key_d;
      evt_type_q  <= evt_type_d;
    end
  end

  assign evt_valid   = evt_valid_q;
  assign evt_key     = evt_key_q;
  assign evt_type    = evt_type_q;
  assign ovf         = ovf_q;
  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed bench for key_event_arbiter: scoreboard of expected events (key, type, cycle) checked on each transfer.
module tb_key_event_arbiter;
  localparam int NK = 4;
  localparam int IW = 2;
  localparam int W  = 4;
  localparam logic [1:0] T_DOWN = 2'b00;
  localparam logic [1:0] T_UP   = 2'b01;
  localparam logic [1:0] T_LONG = 2'b10;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] press_down;
  logic [NK-1:0] press_up;
  logic          evt_valid;
  logic          evt_ready;
  logic [IW-1:0] evt_key;
  logic [1:0]    evt_type;
  logic [NK-1:0] ovf;
  logic          ovf_clr;
  logic [1:0]    dbg_state;
  logic [IW-1:0] dbg_ptr;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  int           exp_t_q[$];

  key_event_arbiter #(.NUM_KEYS(NK), .IDX_W(IW), .LONG_CYCLES(50)) dut (
    .clk        (clk),
    .rst        (rst),
    .press_down (press_down),
    .press_up   (press_up),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_key    (evt_key),
    .evt_type   (evt_type),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr),
    .dbg_state_o(dbg_state),
    .dbg_ptr_o  (dbg_ptr)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [IW-1:0] k, input logic [1:0] ty, input int t);
    exp_q.push_back({k, ty});
    exp_t_q.push_back(t);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_keys(input logic [NK-1:0] dn, input logic [NK-1:0] up, input int n, output int t0);
    t0 = cyc;
    press_down = dn;
    press_up   = up;
    wait_cyc(n);
    press_down = '0;
    press_up   = '0;
  endtask

  task automatic drain(input string tag, input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // scoreboard: every transfer must match the oldest expected event
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    int et;
    if (!rst && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_event observed=%0h expected=none", {evt_key, evt_type});
      end else begin
        e  = exp_q.pop_front();
        et = exp_t_q.pop_front();
        check("event", 32'({evt_key, evt_type}), 32'(e));
        if (et >= 0) check("event_cycle", 32'(cyc), 32'(et));
      end
    end
  end

  initial begin
    int t;
    int t2;
    rst = 1'b1;
    press_down = '0;
    press_up = '0;
    evt_ready = 1'b1;
    ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_key", 32'(evt_key), 32'd0);
    check("rst_type", 32'(evt_type), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_ptr", 32'(dbg_ptr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_cyc(2);

    // simultaneous presses on keys 0,1,3 from ptr 0
    drive_keys(4'b1011, 4'b0000, 1, t);
    push(2'd0, T_DOWN, t + 3);
    push(2'd1, T_DOWN, t + 5);
    push(2'd3, T_DOWN, t + 7);
    drain("drain_multi", 40);
    wait_cyc(2);
    check("ptr_after_multi", 32'(dbg_ptr), 32'd0);

    // single press latency and one-cycle valid
    drive_keys(4'b0100, 4'b0000, 1, t);
    push(2'd2, T_DOWN, t + 3);
    @(negedge clk);
    check("lat_c1", 32'(evt_valid), 32'd0);
    @(negedge clk);
    check("lat_c2", 32'(evt_valid), 32'd0);
    @(negedge clk);
    check("lat_c3", 32'(evt_valid), 32'd1);
    @(negedge clk);
    check("valid_width", 32'(evt_valid), 32'd0);
    drain("drain_single", 10);
    check("ptr_after_single", 32'(dbg_ptr), 32'd3);

    // down and up on one key in the same cycle, search wraps from ptr 3
    wait_cyc(2);
    drive_keys(4'b0001, 4'b0001, 1, t);
    push(2'd0, T_DOWN, t + 3);
    push(2'd0, T_UP, t + 5);
    drain("drain_dn_up", 20);
    wait_cyc(2);
    check("ptr_after_dn_up", 32'(dbg_ptr), 32'd1);

    // backpressure: held event stays stable, repeated press overflows
    evt_ready = 1'b0;
    drive_keys(4'b0100, 4'b0000, 2, t);
    push(2'd2, T_DOWN, -1);
    wait_cyc(1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(evt_valid), 32'd1);
      check("hold_key", 32'(evt_key), 32'd2);
      check("hold_type", 32'(evt_type), 32'(T_DOWN));
    end
    check("ovf_on_repeat", 32'(ovf), 32'b0100);
    @(posedge clk);
    #1;
    evt_ready = 1'b1;
    drain("drain_hold", 5);
    wait_cyc(5);
    check("no_extra_valid", 32'(evt_valid), 32'd0);
    check("ovf_sticky", 32'(ovf), 32'b0100);
    ovf_clr = 1'b1;
    wait_cyc(1);
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'd0);

    // overflow set wins over a simultaneous clear
    t = cyc;
    press_down = 4'b0010;
    wait_cyc(1);
    ovf_clr = 1'b1;
    wait_cyc(1);
    press_down = '0;
    ovf_clr = 1'b0;
    push(2'd1, T_DOWN, t + 3);
    check("ovf_set_beats_clr", 32'(ovf), 32'b0010);
    drain("drain_ovf_prio", 10);
    ovf_clr = 1'b1;
    wait_cyc(1);
    ovf_clr = 1'b0;
    check("ovf_cleared2", 32'(ovf), 32'd0);
    wait_cyc(2);

    // long hold: down, optional long, up
    drive_keys(4'b0010, 4'b0000, 1, t);
    push(2'd1, T_DOWN, t + 3);
`ifdef KEY_EVT_LONG_PRESS_EN
    push(2'd1, T_LONG, t + 53);
`endif
    wait_cyc(t + 100 - cyc);
    drive_keys(4'b0000, 4'b0010, 1, t2);
    check("up_issue_cycle", 32'(t2 - t), 32'd100);
    push(2'd1, T_UP, t2 + 3);
    drain("drain_long", 20);
    wait_cyc(2);

    // asynchronous reset during HOLD
    evt_ready = 1'b0;
    drive_keys(4'b0010, 4'b0000, 2, t);
    wait_cyc(1);
    @(negedge clk);
    check("pre_rst_valid", 32'(evt_valid), 32'd1);
    check("pre_rst_ovf", 32'(ovf), 32'b0010);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(evt_valid), 32'd0);
    check("async_rst_ovf", 32'(ovf), 32'd0);
    check("async_rst_key", 32'(evt_key), 32'd0);
    check("async_rst_state", 32'(dbg_state), 32'd0);
    check("async_rst_ptr", 32'(dbg_ptr), 32'd0);
    wait_cyc(2);
    rst = 1'b0;
    evt_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("no_stale_event", 32'(evt_valid), 32'd0);
    end
    check("post_rst_ovf", 32'(ovf), 32'd0);
    check("post_rst_state", 32'(dbg_state), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
